// File: rtl/jam_host_pkg.sv
// Shared definitions for the jam_host block: state encoding, table geometry
// and result widths used by the host controller and its cost table.
package jam_host_pkg;

  localparam int TABLE_DEPTH = 64;
  localparam int ADDR_W      = 6;
  localparam int IDX_W       = 3;
  localparam int COST_W      = 7;
  localparam int MIN_W       = 10;
  localparam int CNT_W       = 4;
  localparam int WDOG_W      = 20;
  localparam logic [WDOG_W-1:0] WDOG_MAX = 20'd1048575;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_JRST  = 3'd2,
    ST_SERVE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Row-major table index: worker selects the row of eight jobs.
  function automatic logic [ADDR_W-1:0] table_index(input logic [IDX_W-1:0] worker,
                                                    input logic [IDX_W-1:0] job);
    return {worker, job};
  endfunction

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost register file: one synchronous write port, one combinational
// read port, cleared to zero by the asynchronous reset.
module jam_cost_table
  import jam_host_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COST_W-1:0] rd_data
);

  logic [COST_W-1:0] mem [TABLE_DEPTH];

  // Storage array: whole table cleared on reset, single entry written per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jam_host.sv
// Host controller for the assignment engine: loads the cost table, holds the
// engine in reset while loading, serves costs, checks the engine result
// against the expected values and bounds the run with a watchdog.
module jam_host
  import jam_host_pkg::*;
#(
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_MAX
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [MIN_W-1:0]  exp_min,
  input  logic [CNT_W-1:0]  exp_cnt,
  input  logic              load_valid,
  input  logic [COST_W-1:0] load_data,
  output logic              load_ready,
  output logic              jam_rst,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  input  logic              Valid,
  input  logic [MIN_W-1:0]  MinCost,
  input  logic [CNT_W-1:0]  MatchCount,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] ptr;
  logic              jrst_cnt;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_inc;
  logic [MIN_W-1:0]  exp_min_q;
  logic [CNT_W-1:0]  exp_cnt_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;

  logic accept_start;
  logic write_en;
  logic serve_valid;
  logic serve_expire;

  assign wdog_inc = wdog + 1'b1;

  jam_cost_table u_table (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (write_en),
    .wr_addr (ptr),
    .wr_data (load_data),
    .rd_addr (table_index(W, J)),
    .rd_data (Cost)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the control strobes derived from the current state.
  always_comb begin
    state_next   = state;
    load_ready   = 1'b0;
    jam_rst      = 1'b0;
    accept_start = 1'b0;
    write_en     = 1'b0;
    serve_valid  = 1'b0;
    serve_expire = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        jam_rst = (state == ST_IDLE);
        if (start) begin
          accept_start = 1'b1;
          state_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        jam_rst    = 1'b1;
        if (load_valid) begin
          write_en = 1'b1;
          if (ptr == ADDR_W'(TABLE_DEPTH - 1)) begin
            state_next = ST_JRST;
          end
        end
      end
      ST_JRST: begin
        jam_rst = 1'b1;
        if (jrst_cnt) begin
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (Valid) begin
          serve_valid = 1'b1;
          state_next  = ST_DONE;
        end else if (wdog_inc == WDOG_LIMIT) begin
          serve_expire = 1'b1;
          state_next   = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Write pointer walks the table once per run, restarted by an accepted start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= '0;
    end else if (accept_start) begin
      ptr <= '0;
    end else if (write_en) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Two-cycle engine reset window between loading and serving.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      jrst_cnt <= 1'b0;
    end else if (state == ST_JRST) begin
      jrst_cnt <= ~jrst_cnt;
    end else begin
      jrst_cnt <= 1'b0;
    end
  end

  // Watchdog counts serve cycles; it holds its value once the run has ended.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog <= '0;
    end else if (accept_start) begin
      wdog <= '0;
    end else if (state == ST_SERVE) begin
      wdog <= wdog_inc;
    end
  end

  // Expected result captured when a run is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_min_q <= '0;
      exp_cnt_q <= '0;
    end else if (accept_start) begin
      exp_min_q <= exp_min;
      exp_cnt_q <= exp_cnt;
    end
  end

  // Result flags: cleared by a new run, set on the engine strobe or watchdog expiry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (accept_start) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (serve_valid) begin
      done_q    <= 1'b1;
      pass_q    <= (MinCost == exp_min_q) && (MatchCount == exp_cnt_q);
      timeout_q <= 1'b0;
    end else if (serve_expire) begin
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
      timeout_q <= 1'b1;
    end
  end

  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_jam_host.sv
// Directed testbench for jam_host: table load/serve, engine reset window,
// pass/fail compare, watchdog expiry and reset during load.
module tb_jam_host;
  import jam_host_pkg::*;

  localparam int WD = 100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [9:0]  exp_min;
  logic [3:0]  exp_cnt;
  logic        load_valid;
  logic [6:0]  load_data;
  logic        load_ready;
  logic        jam_rst;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic        Valid;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        done;
  logic        pass;
  logic        timeout;

  int total_checks = 0;
  int bad_checks   = 0;

  jam_host #(.WDOG_LIMIT(20'(WD))) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .exp_min    (exp_min),
    .exp_cnt    (exp_cnt),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .jam_rst    (jam_rst),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .Valid      (Valid),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_checks++;
    if (got !== want) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Pulses start for one cycle with the given expectation; ends at a negedge in LOAD.
  task automatic applyStimulus(input logic [9:0] min_v, input logic [3:0] cnt_v);
    exp_min = min_v;
    exp_cnt = cnt_v;
    start   = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
  endtask

  // Loads table[i] = i (i.e. w*8+j); optionally idles a cycle between beats.
  task automatic load_table(input bit toggle);
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 7'(i);
      if (i == 63) checkOutput("ready_before_last_beat", load_ready, 1);
      @(negedge CLK);
      load_valid = 1'b0;
      if (toggle && i != 63) @(negedge CLK);
    end
  endtask

  // Engine reset must be high for exactly two cycles after the last beat.
  task automatic check_jrst();
    checkOutput("jrst_cycle1_jam_rst", jam_rst, 1);
    checkOutput("jrst_cycle1_load_ready", load_ready, 0);
    @(negedge CLK);
    checkOutput("jrst_cycle2_jam_rst", jam_rst, 1);
    @(negedge CLK);
    checkOutput("serve_jam_rst", jam_rst, 0);
  endtask

  task automatic check_cost(input string tag, input logic [2:0] w_v, input logic [2:0] j_v,
                            input logic [6:0] want);
    W = w_v;
    J = j_v;
    #1;
    checkOutput(tag, Cost, want);
  endtask

  initial begin
    RST        = 1'b1;
    start      = 1'b0;
    exp_min    = '0;
    exp_cnt    = '0;
    load_valid = 1'b0;
    load_data  = '0;
    W          = 3'd7;
    J          = 3'd7;
    Valid      = 1'b0;
    MinCost    = '0;
    MatchCount = '0;

    #12;
    checkOutput("rst_load_ready", load_ready, 0);
    checkOutput("rst_jam_rst", jam_rst, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_cost", Cost, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Run 1: toggled load, matching result.
    applyStimulus(10'd0, 4'd1);
    checkOutput("r1_load_ready", load_ready, 1);
    checkOutput("r1_load_jam_rst", jam_rst, 1);
    load_table(1'b1);
    check_jrst();
    check_cost("cost_w3_j5", 3'd3, 3'd5, 7'd29);
    check_cost("cost_w7_j7", 3'd7, 3'd7, 7'd63);
    check_cost("cost_w0_j1", 3'd0, 3'd1, 7'd1);
    Valid      = 1'b1;
    MinCost    = 10'd0;
    MatchCount = 4'd1;
    #1;
    checkOutput("r1_done_not_early", done, 0);
    @(negedge CLK);
    Valid = 1'b0;
    checkOutput("r1_done", done, 1);
    checkOutput("r1_pass", pass, 1);
    checkOutput("r1_timeout", timeout, 0);
    checkOutput("r1_done_jam_rst", jam_rst, 0);
    check_cost("done_cost_w5_j2", 3'd5, 3'd2, 7'd42);

    // Run 2: Valid during LOAD ignored, mismatching result.
    applyStimulus(10'd0, 4'd1);
    checkOutput("r2_done_cleared", done, 0);
    checkOutput("r2_pass_cleared", pass, 0);
    Valid = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    checkOutput("r2_valid_in_load_ignored", done, 0);
    checkOutput("r2_still_loading", load_ready, 1);
    load_table(1'b0);
    check_jrst();
    Valid      = 1'b1;
    MinCost    = 10'd5;
    MatchCount = 4'd1;
    @(negedge CLK);
    Valid = 1'b0;
    checkOutput("r2_done", done, 1);
    checkOutput("r2_pass", pass, 0);
    checkOutput("r2_timeout", timeout, 0);

    // Run 3: watchdog expiry.
    applyStimulus(10'd0, 4'd1);
    load_table(1'b0);
    check_jrst();
    repeat (WD - 1) @(negedge CLK);
    checkOutput("r3_done_before_limit", done, 0);
    @(negedge CLK);
    checkOutput("r3_done", done, 1);
    checkOutput("r3_timeout", timeout, 1);
    checkOutput("r3_pass", pass, 0);

    // Run 4: Valid on the watchdog's final cycle wins.
    applyStimulus(10'd0, 4'd1);
    load_table(1'b0);
    check_jrst();
    repeat (WD - 1) @(negedge CLK);
    Valid      = 1'b1;
    MinCost    = 10'd0;
    MatchCount = 4'd1;
    @(negedge CLK);
    Valid = 1'b0;
    checkOutput("r4_done", done, 1);
    checkOutput("r4_pass", pass, 1);
    checkOutput("r4_timeout", timeout, 0);

    // Run 5: reset after 20 beats of a new load.
    applyStimulus(10'd0, 4'd1);
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = 7'(100 + i);
      @(negedge CLK);
    end
    load_valid = 1'b0;
    check_cost("r5_partial_w2_j3", 3'd2, 3'd3, 7'd119);
    check_cost("r5_old_w7_j7", 3'd7, 3'd7, 7'd63);
    RST = 1'b1;
    #1;
    checkOutput("r5_rst_load_ready", load_ready, 0);
    checkOutput("r5_rst_jam_rst", jam_rst, 1);
    checkOutput("r5_rst_done", done, 0);
    checkOutput("r5_rst_pass", pass, 0);
    checkOutput("r5_rst_timeout", timeout, 0);
    checkOutput("r5_rst_cost_w7_j7", Cost, 0);
    check_cost("r5_rst_cost_w2_j3", 3'd2, 3'd3, 7'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    applyStimulus(10'd3, 4'd2);
    checkOutput("r5_restart_load_ready", load_ready, 1);
    checkOutput("r5_restart_jam_rst", jam_rst, 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
